pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator; successor to the single-channel fixed-period PWM block.
N channels share one period counter. Each channel has its own duty value.
Period, duty and alignment mode are runtime-programmable through shadow registers, applied glitch-free at period boundaries.
Sits between the register/control interface and the pad or driver logic.

Parameters:
NCH, 4, number of PWM channels (1..16)
CNT_W, 8, counter/period/duty width in bits
RST_PERIOD, 9, period value loaded at reset (gives 10-cycle edge-aligned period)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  run enable; low forces IDLE synchronously
cfg_load  in  1  one-cycle strobe; captures cfg_period, cfg_duty, cfg_center into pending shadow
cfg_period  in  CNT_W  period value P
cfg_duty  in  NCH*CNT_W  duty per channel; channel i at bits [i*CNT_W +: CNT_W]
cfg_center  in  1  0 = edge-aligned, 1 = center-aligned
cfg_pending  out  1  high while a captured config waits for a boundary
cnt  out  CNT_W  current counter value (debug/verification)
period_tick  out  1  one-cycle pulse on the first cycle of every period
pwm_out  out  NCH  PWM outputs

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; cnt=0; pwm_out=0; period_tick=0; cfg_pending=0.
  - Active period=RST_PERIOD; active duty=0 all channels; mode=edge.
- FSM states: IDLE, UP, DOWN. All outputs are registered.
- IDLE:
  - cnt=0, pwm_out=0, period_tick=0.
  - en=1 sampled -> UP next cycle, with cnt=0 and period_tick=1 in that cycle.
- UP:
  - cnt < P: cnt+1.
  - cnt == P, edge mode: cnt wraps to 0, stay UP.
  - cnt == P, center mode: go to DOWN with cnt=P-1.
- DOWN:
  - cnt decrements.
  - cnt == 1: next is cnt=0, state UP.
- Period lengths: edge = P+1 cycles; center = 2*P cycles.
- P=0 (either mode): cnt held at 0, period_tick=1 every cycle, pwm_out[i] = (duty[i] != 0).
- Output relation, every non-IDLE cycle: pwm_out[i] = (cnt < duty[i]) for the cnt value shown in that same cycle.
  - duty=0 -> constant 0.
  - duty > P -> constant 1.
  - Center mode gives a pulse symmetric about cnt=0.
- period_tick=1 exactly in cycles where cnt=0 and state is UP on entry (wrap or leaving DOWN, or first cycle after IDLE).
- Config shadowing:
  - cfg_load=1 captures all cfg_* into pending and sets cfg_pending=1.
  - A second cfg_load before apply overwrites pending (last wins).
  - Apply point: the cycle where the next cnt is 0 and a new period begins. Pending becomes active in that new period's first cycle; cfg_pending clears the same cycle.
  - In IDLE (en=0), pending is applied on the next cycle.
  - cfg_load coinciding with an apply point: the new value is captured as pending for the following boundary; the old pending is applied.
- en deasserted mid-period: next cycle is IDLE; cnt=0 and pwm_out=0 immediately. The period is truncated; no partial-period completion.
- reset mid-operation: immediate return to reset values. Pending config is discarded.
- Mode change takes effect only at an apply point; the counter always restarts from 0, UP.
- Comparisons are unsigned, CNT_W bits. No internal arithmetic exceeds CNT_W; cnt never exceeds P.

Decomposition:
- Package pwm_multi_pkg:
  - FSM state enum (IDLE/UP/DOWN).
  - Mode constants (MODE_EDGE=0, MODE_CENTER=1).
- Sub-module pwm_cmp_chan, instantiated NCH times via generate:
  - Holds the active duty register.
  - Registered compare output.
- The top holds the FSM, counter and shadow/pending logic.

Test Plan:
1. Reset defaults, en=1, no cfg: period 10 cycles, period_tick every 10 cycles, all pwm_out=0, cnt sequence 0..9.
2. Edge mode, P=9, duties {0,3,9,10}, cfg_load in IDLE then en=1 -> ch0 always 0; ch1 high 3 of 10 cycles; ch2 high 9 of 10; ch3 always 1.
3. Center mode, P=4, duty ch0=2 -> cnt 0,1,2,3,4,3,2,1 repeating (8 cycles); pwm_out[0] high at cnt 0,1 and cnt 1 on the down slope (3 of 8), symmetric about cnt=0.
4. Running edge P=9, cfg_load duty ch0=5 at cnt=4 -> cfg_pending=1 until next cnt=0; the current period keeps the old duty; the new duty starts with the period_tick cycle.
5. Two cfg_load strobes (duty 2 then 7) within one period -> only 7 is applied at the boundary; 2 never appears on pwm_out.
6. en dropped at cnt=6 with outputs high -> next cycle cnt=0, pwm_out=0, IDLE. Then assert reset mid-run with pending config -> async clear; after release, the RST_PERIOD defaults are in effect.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
//   state_t     : counter FSM state (IDLE / UP / DOWN)
//   MODE_EDGE   : edge-aligned counting (0..P, wrap)
//   MODE_CENTER : center-aligned counting (0..P..1, repeat)
package pwm_multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

endpackage

// File: rtl/pwm_multi_gen_if.sv
// Configuration bus of the PWM generator.
//   cfg_load    : one-cycle strobe capturing period/duty/mode into the shadow
//   cfg_period  : period value P
//   cfg_duty    : packed duties, channel i at [i*CNT_W +: CNT_W]
//   cfg_center  : 0 = edge-aligned, 1 = center-aligned
//   cfg_pending : high while a captured config waits for a period boundary
// master drives the config, slave is the generator.
interface pwm_multi_gen_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);

  logic                   cfg_load;
  logic [CNT_W-1:0]       cfg_period;
  logic [NCH*CNT_W-1:0]   cfg_duty;
  logic                   cfg_center;
  logic                   cfg_pending;

  modport master (
    output cfg_load, cfg_period, cfg_duty, cfg_center,
    input  cfg_pending
  );

  modport slave (
    input  cfg_load, cfg_period, cfg_duty, cfg_center,
    output cfg_pending
  );

endinterface

// File: rtl/pwm_cmp_chan.sv
// One PWM channel: active duty register plus registered compare output.
//   clk, reset : clock, asynchronous active-low reset
//   apply      : load pend_duty into the active duty at this edge
//   pend_duty  : shadow duty value to become active on apply
//   run_next   : counter will be running (not IDLE) in the next cycle
//   cnt_next   : counter value of the next cycle
//   pwm        : registered output, (cnt < duty) for the cycle it is shown in
module pwm_cmp_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apply,
  input  logic [CNT_W-1:0] pend_duty,
  input  logic             run_next,
  input  logic [CNT_W-1:0] cnt_next,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] duty_next_s;
  logic             pwm_r;

  // Duty seen in the next cycle; the compare must use the freshly applied
  // value so a new duty starts exactly with the new period's first cycle.
  always_comb begin
    duty_next_s = duty_r;
    if (apply) begin
      duty_next_s = pend_duty;
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Active duty register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_r <= {CNT_W{1'b0}};
    end else begin
      duty_r <= duty_next_s;
    end
  end

  // Compare against next-cycle counter so the registered output lines up
  // with the counter value displayed in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= run_next && (cnt_next < duty_next_s);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty,
// edge or center alignment, shadowed configuration applied at boundaries.
//   clk, reset  : clock, asynchronous active-low reset
//   en          : run enable; low returns to IDLE on the next cycle
//   cfg         : configuration bus (slave modport)
//   cnt         : current counter value
//   period_tick : pulse on the first cycle of every period
//   pwm_out     : PWM outputs, one bit per channel
module pwm_multi_gen
  import pwm_multi_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  pwm_multi_gen_if.slave     cfg,
  output logic [CNT_W-1:0]   cnt,
  output logic               period_tick,
  output logic [NCH-1:0]     pwm_out
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  state_t               state_r;
  state_t               state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_next_s;
  logic                 tick_r;
  logic                 tick_next_s;
  logic                 boundary_s;
  logic                 apply_s;
  logic                 run_next_s;

  logic [CNT_W-1:0]     period_r;
  logic                 mode_r;
  logic                 pend_valid_r;
  logic [CNT_W-1:0]     pend_period_r;
  logic [NCH*CNT_W-1:0] pend_duty_r;
  logic                 pend_mode_r;

  // Next-state / next-counter logic; boundary_s marks the start of a period.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    tick_next_s  = 1'b0;
    boundary_s   = 1'b0;
    if (!en) begin
      state_next_s = IDLE;
      cnt_next_s   = ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = UP;
          cnt_next_s   = ZERO;
          tick_next_s  = 1'b1;
          boundary_s   = 1'b1;
        end
        UP: begin
          if (cnt_r < period_r) begin
            cnt_next_s = cnt_r + ONE;
          end else if ((mode_r == MODE_CENTER) && (period_r > ONE)) begin
            state_next_s = DOWN;
            cnt_next_s   = period_r - ONE;
          end else begin
            // Edge wrap; also P=0 and center P=1 where there is no down slope.
            state_next_s = UP;
            cnt_next_s   = ZERO;
            tick_next_s  = 1'b1;
            boundary_s   = 1'b1;
          end
        end
        DOWN: begin
          if (cnt_r > ONE) begin
            cnt_next_s = cnt_r - ONE;
          end else begin
            state_next_s = UP;
            cnt_next_s   = ZERO;
            tick_next_s  = 1'b1;
            boundary_s   = 1'b1;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = ZERO;
        end
      endcase
    end
  end

  // Pending config takes over at a period start, or straight away when idle.
  assign apply_s    = pend_valid_r && (boundary_s || (state_r == IDLE));
  assign run_next_s = (state_next_s != IDLE);

  // FSM state, counter and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      tick_r  <= tick_next_s;
    end
  end

  // Active period/mode and shadow registers. A load coinciding with an
  // apply keeps pending set: the old shadow is applied, the new one waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_r      <= CNT_W'(RST_PERIOD);
      mode_r        <= MODE_EDGE;
      pend_valid_r  <= 1'b0;
      pend_period_r <= ZERO;
      pend_duty_r   <= {(NCH*CNT_W){1'b0}};
      pend_mode_r   <= MODE_EDGE;
    end else begin
      if (apply_s) begin
        period_r <= pend_period_r;
        mode_r   <= pend_mode_r;
      end else begin
        period_r <= period_r;
        mode_r   <= mode_r;
      end
      if (cfg.cfg_load) begin
        pend_valid_r  <= 1'b1;
        pend_period_r <= cfg.cfg_period;
        pend_duty_r   <= cfg.cfg_duty;
        pend_mode_r   <= cfg.cfg_center;
      end else if (apply_s) begin
        pend_valid_r  <= 1'b0;
      end else begin
        pend_valid_r  <= pend_valid_r;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      pwm_cmp_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .apply     (apply_s),
        .pend_duty (pend_duty_r[gi*CNT_W +: CNT_W]),
        .run_next  (run_next_s),
        .cnt_next  (cnt_next_s),
        .pwm       (pwm_out[gi])
      );
    end
  endgenerate

  assign cnt             = cnt_r;
  assign period_tick     = tick_r;
  assign cfg.cfg_pending = pend_valid_r;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed steps followed by random
// enable/config traffic, compared against a period-phase reference model.
module tb_pwm_multi_gen;

  localparam int NCH        = 4;
  localparam int CNT_W      = 8;
  localparam int RST_PERIOD = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [CNT_W-1:0] cnt;
  logic             period_tick;
  logic [NCH-1:0]   pwm_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_multi_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg_bus ();

  pwm_multi_gen #(
    .NCH        (NCH),
    .CNT_W      (CNT_W),
    .RST_PERIOD (RST_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg         (cfg_bus),
    .cnt         (cnt),
    .period_tick (period_tick),
    .pwm_out     (pwm_out)
  );

  // Reference model: running flag, phase k within the period, configs.
  int m_idle, m_k, m_per, m_center;
  int m_duty [NCH];
  int p_valid, p_per, p_center;
  int p_duty [NCH];

  task automatic model_reset();
    m_idle = 1; m_k = 0; m_per = RST_PERIOD; m_center = 0; p_valid = 0;
    p_per = 0; p_center = 0;
    for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; p_duty[i] = 0; end
  endtask

  function automatic int m_len();
    if (m_per == 0) return 1;
    return m_center ? 2 * m_per : m_per + 1;
  endfunction

  function automatic int m_cnt();
    if (m_idle) return 0;
    if (m_center && m_k > m_per) return 2 * m_per - m_k;
    return m_k;
  endfunction

  // Advance the model over one clock edge with the inputs present at it.
  task automatic model_edge(input logic e, input logic ld);
    int was_idle;
    int apply;
    was_idle = m_idle;
    apply = 0;
    if (!e) begin
      m_idle = 1;
      apply = was_idle;
    end else if (was_idle) begin
      m_idle = 0; m_k = 0; apply = 1;
    end else begin
      m_k = m_k + 1;
      if (m_k >= m_len()) begin m_k = 0; apply = 1; end
    end
    if (apply && p_valid) begin
      m_per = p_per; m_center = p_center; p_valid = 0;
      for (int i = 0; i < NCH; i++) m_duty[i] = p_duty[i];
    end
    if (ld) begin
      p_valid = 1; p_per = int'(cfg_bus.cfg_period); p_center = int'(cfg_bus.cfg_center);
      for (int i = 0; i < NCH; i++) p_duty[i] = int'(cfg_bus.cfg_duty[i*CNT_W +: CNT_W]);
    end
  endtask

  task automatic check(input string tag);
    logic [CNT_W-1:0] e_cnt;
    logic             e_tick;
    logic [NCH-1:0]   e_pwm;
    logic             e_pend;
    e_cnt  = CNT_W'(m_cnt());
    e_tick = (!m_idle && m_k == 0);
    e_pend = (p_valid != 0);
    for (int i = 0; i < NCH; i++) e_pwm[i] = !m_idle && (m_cnt() < m_duty[i]);
    checks += 4;
    assert (cnt === e_cnt) else begin
      failures++; $error("FAIL %s cnt: got %0d expected %0d", tag, cnt, e_cnt);
    end
    assert (period_tick === e_tick) else begin
      failures++; $error("FAIL %s period_tick: got %b expected %b", tag, period_tick, e_tick);
    end
    assert (pwm_out === e_pwm) else begin
      failures++; $error("FAIL %s pwm_out: got %b expected %b", tag, pwm_out, e_pwm);
    end
    assert (cfg_bus.cfg_pending === e_pend) else begin
      failures++; $error("FAIL %s cfg_pending: got %b expected %b", tag, cfg_bus.cfg_pending, e_pend);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge(en, cfg_bus.cfg_load);
    #1;
    check(tag);
  endtask

  function automatic logic [NCH*CNT_W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [CNT_W-1:0] a, b, c, d;
    a = CNT_W'(d0); b = CNT_W'(d1); c = CNT_W'(d2); d = CNT_W'(d3);
    return {d, c, b, a};
  endfunction

  task automatic load_cfg(input string tag, input int per, input logic [NCH*CNT_W-1:0] duty, input logic center);
    cfg_bus.cfg_period = CNT_W'(per);
    cfg_bus.cfg_duty   = duty;
    cfg_bus.cfg_center = center;
    cfg_bus.cfg_load   = 1'b1;
    cyc(tag);
    cfg_bus.cfg_load   = 1'b0;
  endtask

  // Step until the model shows the wanted counter value; an expired bound fails.
  task automatic wait_cnt(input string tag, input int want);
    int found;
    found = 0;
    for (int n = 0; n < 60; n++) begin
      if (!m_idle && !p_valid && m_cnt() == want) begin found = 1; break; end
      cyc(tag);
    end
    checks++;
    assert (found == 1) else begin
      failures++; $error("FAIL %s wait: got no cnt=%0d expected within 60 cycles", tag, want);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0;
    cfg_bus.cfg_load = 1'b0; cfg_bus.cfg_period = '0;
    cfg_bus.cfg_duty = '0; cfg_bus.cfg_center = 1'b0;
    model_reset();
    #12;
    check("reset");
    reset = 1'b1;

    // 1: defaults, 10-cycle edge period, all outputs low
    en = 1'b1;
    repeat (22) cyc("default_run");

    // 2: edge P=9, duties {0,3,9,10} loaded in IDLE
    en = 1'b0;
    cyc("idle");
    load_cfg("load_idle", 9, pack(0, 3, 9, 10), 1'b0);
    cyc("apply_idle");
    en = 1'b1;
    repeat (22) cyc("edge_run");

    // 3: center P=4, ch0 duty 2, switched while running
    load_cfg("load_center", 4, pack(2, 0, 5, 1), 1'b1);
    repeat (26) cyc("center_run");

    // 4: edge P=9, change ch0 duty to 5 at cnt=4
    load_cfg("load_edge", 9, pack(1, 3, 9, 10), 1'b0);
    wait_cnt("wait4", 4);
    load_cfg("load_mid", 9, pack(5, 3, 9, 10), 1'b0);
    repeat (14) cyc("mid_apply");

    // 5: two loads in one period, last wins
    wait_cnt("wait2", 2);
    load_cfg("load_d2", 9, pack(2, 3, 9, 10), 1'b0);
    cyc("between");
    load_cfg("load_d7", 9, pack(7, 3, 9, 10), 1'b0);
    repeat (14) cyc("last_wins");

    // 6: en dropped at cnt=6, then reset with pending config
    wait_cnt("wait6", 6);
    en = 1'b0;
    cyc("en_drop");
    en = 1'b1;
    repeat (5) cyc("rerun");
    load_cfg("load_pre_rst", 3, pack(1, 2, 3, 4), 1'b1);
    #2 reset = 1'b0;
    #3 model_reset();
    check("async_rst");
    reset = 1'b1;
    repeat (22) cyc("post_rst");

    // Boundary periods: P=0 and center P=1
    load_cfg("load_p0", 0, pack(0, 1, 2, 0), 1'b0);
    repeat (6) cyc("p0_run");
    load_cfg("load_c1", 1, pack(0, 1, 2, 3), 1'b1);
    repeat (8) cyc("c1_run");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 11) == 0) begin
        int per;
        per = int'($urandom_range(0, 12));
        load_cfg("rand_load", per,
                 pack(int'($urandom_range(0, per + 2)), int'($urandom_range(0, per + 2)),
                      int'($urandom_range(0, per + 2)), int'($urandom_range(0, per + 2))),
                 1'($urandom_range(0, 1)));
      end else begin
        cyc("rand_run");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
